// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
//   rx_state_t       : receive FSM states
//   END_WORD_DEFAULT : default end-of-program marker word
//   BYTES_PER_WORD   : UART bytes that make up one instruction word
package uart_prog_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [31:0] END_WORD_DEFAULT = 32'h0000_0FFF;
    localparam int          BYTES_PER_WORD   = 4;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write bus driven by the program loader.
//   mem_we    : one-cycle write strobe
//   mem_addr  : word address of the write
//   mem_wdata : write data
// Modports: master (loader side), slave (memory side).
interface uart_prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        input mem_we,
        input mem_addr,
        input mem_wdata
    );
endinterface

// File: rtl/uart_prog_loader_rx_byte.sv
// UART byte receiver: 2-flop synchronizer, receive FSM and bit timer.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   enable      : when low the FSM is held in idle and emits nothing
//   rx          : asynchronous serial input, idle high
//   byte_valid  : one-cycle pulse, byte_data holds a good byte
//   byte_data   : received byte
//   frame_err   : one-cycle pulse, stop bit sampled low (byte dropped)
//
// state    | meaning
// RX_IDLE  | waiting for a start edge (only once re-armed by a high line)
// RX_START | timing to mid start bit, rejecting glitches
// RX_DATA  | sampling 8 data bits LSB first at mid-bit
// RX_STOP  | sampling the stop bit
module uart_rx_byte
    import uart_prog_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4167
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    // Down-counter loads; a sample is taken when the counter reaches zero.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta;
    logic             rx_sync;
    rx_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_next;
    logic             armed, armed_next;
    logic             shift_en;
    logic             valid_next;
    logic             ferr_next;
    logic [7:0]       shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            armed      <= 1'b1;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            state      <= state_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_next;
            armed      <= armed_next;
            byte_valid <= valid_next;
            frame_err  <= ferr_next;
            if (shift_en) begin
                shreg <= {rx_sync, shreg[7:1]};
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        armed_next = armed;
        shift_en   = 1'b0;
        valid_next = 1'b0;
        ferr_next  = 1'b0;

        if (!enable) begin
            state_next = RX_IDLE;
        end else begin
            case (state)
                RX_IDLE: begin
                    // After a low stop bit the line must go high before a
                    // new start bit is accepted.
                    if (!armed) begin
                        if (rx_sync) armed_next = 1'b1;
                    end else if (!rx_sync) begin
                        state_next = RX_START;
                        cnt_next   = HALF_LOAD;
                    end
                end
                RX_START: begin
                    if (cnt == '0) begin
                        if (rx_sync) begin
                            state_next = RX_IDLE;
                        end else begin
                            state_next = RX_DATA;
                            cnt_next   = BIT_LOAD;
                            bit_next   = '0;
                        end
                    end else begin
                        cnt_next = cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == '0) begin
                        shift_en = 1'b1;
                        cnt_next = BIT_LOAD;
                        if (bit_idx == 3'd7) begin
                            state_next = RX_STOP;
                        end else begin
                            bit_next = bit_idx + 1'b1;
                        end
                    end else begin
                        cnt_next = cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == '0) begin
                        state_next = RX_IDLE;
                        armed_next = rx_sync;
                        if (rx_sync) valid_next = 1'b1;
                        else         ferr_next  = 1'b1;
                    end else begin
                        cnt_next = cnt - 1'b1;
                    end
                end
                default: state_next = RX_IDLE;
            endcase
        end
    end

    assign byte_data = shreg;

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot-image loader. Assembles received bytes into little-endian
// 32-bit words and writes them sequentially to instruction memory from
// word 0; holds the core in reset until the end-of-program marker arrives.
// Ports:
//   wb_clk_i     : clock
//   wb_rst_i     : synchronous active-high reset
//   rx_i         : UART serial input, idle high
//   mem          : instruction-memory write bus (master)
//   prog_done_o  : sticky, marker word received
//   core_rst_o   : core reset, active-high (~prog_done_o)
//   frame_err_o  : sticky, a stop bit was sampled low
//   ovf_o        : sticky, a word arrived with memory already full
module uart_prog_loader
    import uart_prog_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 4167,
    parameter int          ADDR_W       = 10,
    parameter logic [31:0] END_WORD     = END_WORD_DEFAULT
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                rx_i,
    uart_prog_loader_if.master  mem,
    output logic                prog_done_o,
    output logic                core_rst_o,
    output logic                frame_err_o,
    output logic                ovf_o
);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ferr;

    logic [1:0]        byte_cnt;
    logic [23:0]       word_buf;
    logic [31:0]       word_full;
    // One extra bit so a full memory is distinguishable and never wraps.
    logic [ADDR_W:0]   ptr;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              done_q;
    logic              ferr_q;
    logic              ovf_q;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .enable     (~done_q),
        .rx         (rx_i),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .frame_err  (rx_ferr)
    );

    // The 4th byte completes the word; it is processed on the same edge so
    // the write / done / overflow result is visible the following cycle.
    assign word_full = {rx_data, word_buf};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            byte_cnt <= '0;
            word_buf <= '0;
            ptr      <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (!done_q) begin
                if (rx_ferr) begin
                    ferr_q <= 1'b1;
                end
                if (rx_valid) begin
                    if (byte_cnt == LAST_BYTE) begin
                        byte_cnt <= '0;
                        if (word_full == END_WORD) begin
                            done_q <= 1'b1;
                        end else if (!ptr[ADDR_W]) begin
                            we_q    <= 1'b1;
                            addr_q  <= ptr[ADDR_W-1:0];
                            wdata_q <= word_full;
                            ptr     <= ptr + 1'b1;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end else begin
                        word_buf[{byte_cnt, 3'b000} +: 8] <= rx_data;
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign prog_done_o   = done_q;
    assign core_rst_o    = ~done_q;
    assign frame_err_o   = ferr_q;
    assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with CLKS_PER_BIT=16, ADDR_W=2.
module tb_uart_prog_loader;
    localparam int CPB    = 16;
    localparam int ADDR_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic prog_done, core_rst, frame_err, ovf;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];

    uart_prog_loader_if #(.ADDR_W(ADDR_W)) mem_bus ();

    uart_prog_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (ADDR_W),
        .END_WORD     (32'h0000_0FFF)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .rx_i        (rx),
        .mem         (mem_bus.master),
        .prog_done_o (prog_done),
        .core_rst_o  (core_rst),
        .frame_err_o (frame_err),
        .ovf_o       (ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_bus.mem_we === 1'b1) begin
            wa.push_back(32'(mem_bus.mem_addr));
            wd.push_back(mem_bus.mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] wr_addr(input int i);
        return (i < wa.size()) ? wa[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] wr_data(input int i);
        return (i < wd.size()) ? wd[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rx  = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        wa.delete();
        wd.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0],   1'b1);
        send_byte(w[15:8],  1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[31:24], 1'b1);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_we",        32'(mem_bus.mem_we),   32'd0);
        check("rst_addr",      32'(mem_bus.mem_addr), 32'd0);
        check("rst_wdata",     mem_bus.mem_wdata,     32'd0);
        check("rst_done",      32'(prog_done),        32'd0);
        check("rst_core_rst",  32'(core_rst),         32'd1);
        check("rst_frame_err", 32'(frame_err),        32'd0);
        check("rst_ovf",       32'(ovf),              32'd0);

        // Single word 13 00 00 00
        send_word(32'h0000_0013);
        check("w1_count",    32'(wa.size()), 32'd1);
        check("w1_addr",     wr_addr(0),     32'd0);
        check("w1_data",     wr_data(0),     32'h0000_0013);
        check("w1_core_rst", 32'(core_rst),  32'd1);
        check("w1_hold_addr",  32'(mem_bus.mem_addr), 32'd0);
        check("w1_hold_wdata", mem_bus.mem_wdata,     32'h0000_0013);

        // Two words then end marker; later traffic ignored
        do_reset();
        send_word(32'h1122_3344);
        send_word(32'hDEAD_BEEF);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h0F, 1'b1);
        send_byte(8'h00, 1'b1);
        check("end_pre_done", 32'(prog_done), 32'd0);
        send_byte(8'h00, 1'b1);
        check("end_done",     32'(prog_done), 32'd1);
        check("end_core_rst", 32'(core_rst),  32'd0);
        check("end_count",    32'(wa.size()), 32'd2);
        check("end_addr0",    wr_addr(0),     32'd0);
        check("end_data0",    wr_data(0),     32'h1122_3344);
        check("end_addr1",    wr_addr(1),     32'd1);
        check("end_data1",    wr_data(1),     32'hDEAD_BEEF);
        send_word(32'h5566_7788);
        send_byte(8'h12, 1'b0);
        check("post_count",     32'(wa.size()), 32'd2);
        check("post_done",      32'(prog_done), 32'd1);
        check("post_frame_err", 32'(frame_err), 32'd0);

        // Frame error, then a clean word
        do_reset();
        send_byte(8'h5A, 1'b0);
        check("ferr_flag",  32'(frame_err), 32'd1);
        check("ferr_nowr",  32'(wa.size()), 32'd0);
        send_word(32'hCAFE_F00D);
        check("ferr_count", 32'(wa.size()), 32'd1);
        check("ferr_addr",  wr_addr(0),     32'd0);
        check("ferr_data",  wr_data(0),     32'hCAFE_F00D);

        // Short low glitch rejected at mid-start sample
        do_reset();
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_nowr", 32'(wa.size()), 32'd0);
        check("glitch_ferr", 32'(frame_err), 32'd0);
        check("glitch_ovf",  32'(ovf),       32'd0);
        send_word(32'h0102_0304);
        check("glitch_count", 32'(wa.size()), 32'd1);
        check("glitch_data",  wr_data(0),     32'h0102_0304);

        // Fill the 4-word memory, 5th word overflows
        do_reset();
        for (int i = 0; i < 4; i++) send_word(32'hA5A5_0000 | 32'(i));
        check("ovf_before", 32'(ovf), 32'd0);
        send_word(32'hA5A5_0004);
        check("ovf_flag",  32'(ovf),       32'd1);
        check("ovf_count", 32'(wa.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_addr%0d", i), wr_addr(i), 32'(i));
            check($sformatf("ovf_data%0d", i), wr_data(i), 32'hA5A5_0000 | 32'(i));
        end
        check("ovf_done", 32'(prog_done), 32'd0);

        // Set frame error too, then reset mid-word
        send_byte(8'h77, 1'b0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check("mid_pre_ferr", 32'(frame_err), 32'd1);
        do_reset();
        check("mid_ovf",      32'(ovf),       32'd0);
        check("mid_ferr",     32'(frame_err), 32'd0);
        check("mid_done",     32'(prog_done), 32'd0);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        check("mid_count", 32'(wa.size()), 32'd1);
        check("mid_addr",  wr_addr(0),     32'd0);
        check("mid_data",  wr_data(0),     32'hDDCC_BBAA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
